wb_stage: RTL and testbench

- Final pipeline stage of the RISC-V core. Captures the MEM-stage instruction, selects and formats its writeback data, and drives the register-file write port consumed by decode (wb_regwen, wb_fpregwen, wb_wdata, wb_inst).
- Also arbitrates that single write port with a long-latency FP divide/sqrt unit through a small result queue.
- Stalls the front of the pipeline when the queue starves.

---
 rtl/wb_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Small generic FIFO with occupancy count; head is visible combinationally.
// Latency: a pushed entry appears at the head no earlier than the next cycle (no bypass).
// Backpressure: in_rdy = count < DEPTH; push and pop together on a full FIFO cannot occur.
module wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [WIDTH-1:0]             in_dat,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [WIDTH-1:0]             out_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_rdy  = (count < CW'(DEPTH));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Storage array; payload needs no reset because count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Writeback stage: formats MEM results and shares the regfile write port with an FPU result queue.
// Latency: 1 cycle MEM -> WB outputs; queued FPU results drain on cycles the pipeline does not write.
// Backpressure: fpu_ready drops when the queue is full; wb_stall_req asks for a bubble after prolonged starvation.
module wb_stage #(
    parameter int FPQ_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu,
    input  logic [31:0] wb_dmem_rdata,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_rd,
    input  logic        fpu_fp_dest,
    input  logic [31:0] fpu_result,
    output logic        fpu_ready,
    output logic        wb_regwen,
    output logic        wb_fpregwen,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_inst,
    output logic        wb_stall_req
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int QCW = $clog2(FPQ_DEPTH+1);
    localparam int SCW = $clog2(STARVE_LIMIT+1);

    typedef struct packed {
        logic [4:0]  rd;
        logic        fp_dest;
        logic [31:0] result;
    } fpq_ent_t;

    logic [31:0]    inst_q;
    logic [31:0]    pc_q;
    logic [31:0]    alu_q;
    logic [SCW-1:0] starve_cnt;

    fpq_ent_t       fpq_in;
    fpq_ent_t       fpq_head;
    logic           fpq_head_vld;
    logic           fpq_pop;
    logic [QCW-1:0] fpq_count;
    logic           fpq_full;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [4:0]     funct5;
    logic [4:0]     rd;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;
    logic [31:0]    pipe_data;
    logic           cls_int;
    logic           cls_fp;
    logic           pipe_int;

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];
    assign funct5 = inst_q[31:27];
    assign rd     = inst_q[11:7];

    // MEM -> WB capture; a stalled MEM stage turns into a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= NOP;
            pc_q   <= '0;
            alu_q  <= '0;
        end else begin
            inst_q <= mem_stall ? NOP : mem_inst;
            pc_q   <= mem_pc;
            alu_q  <= mem_alu;
        end
    end

    assign fpq_in = '{rd: fpu_rd, fp_dest: fpu_fp_dest, result: fpu_result};

    wb_fifo #(
        .WIDTH ($bits(fpq_ent_t)),
        .DEPTH (FPQ_DEPTH)
    ) u_fpq (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (fpu_valid),
        .in_rdy  (fpu_ready),
        .in_dat  (fpq_in),
        .out_vld (fpq_head_vld),
        .out_rdy (fpq_pop),
        .out_dat (fpq_head),
        .count   (fpq_count)
    );

    assign fpq_full = (fpq_count == QCW'(FPQ_DEPTH));

    // Load alignment: pick byte/half lane from the read word using the low address bits.
    always_comb begin
        ld_byte = wb_dmem_rdata[7:0];
        case (alu_q[1:0])
            2'd1:    ld_byte = wb_dmem_rdata[15:8];
            2'd2:    ld_byte = wb_dmem_rdata[23:16];
            2'd3:    ld_byte = wb_dmem_rdata[31:24];
            default: ld_byte = wb_dmem_rdata[7:0];
        endcase
        ld_half = alu_q[1] ? wb_dmem_rdata[31:16] : wb_dmem_rdata[15:0];
        case (funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = wb_dmem_rdata;
        endcase
    end

    // Classify the WB instruction into int write / FP write / none and select its data.
    always_comb begin
        cls_int   = 1'b0;
        cls_fp    = 1'b0;
        pipe_data = alu_q;
        case (opcode)
            7'b0000011: begin
                cls_int   = 1'b1;
                pipe_data = ld_data;
            end
            7'b1101111, 7'b1100111: begin
                cls_int   = 1'b1;
                pipe_data = pc_q + 32'd4;
            end
            7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011: begin
                cls_int = 1'b1;
            end
            7'b0000111: begin
                cls_fp    = 1'b1;
                pipe_data = wb_dmem_rdata;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                cls_fp = 1'b1;
            end
            7'b1010011: begin
                case (funct5)
                    5'b11100, 5'b11000, 5'b10100: cls_int = 1'b1;
                    5'b00011, 5'b01011:           cls_fp  = 1'b0; // result comes back through the queue
                    default:                      cls_fp  = 1'b1;
                endcase
            end
            default: begin
                cls_int = 1'b0;
            end
        endcase
    end

    // Writes to x0 are dropped, which also frees the port for the queue.
    assign pipe_int = cls_int & (rd != 5'd0);

    // Write-port arbitration: pipeline first, then the queue head, else idle.
    always_comb begin
        wb_regwen   = 1'b0;
        wb_fpregwen = 1'b0;
        wb_wdata    = '0;
        wb_inst     = inst_q;
        fpq_pop     = 1'b0;
        if (pipe_int || cls_fp) begin
            wb_regwen   = pipe_int;
            wb_fpregwen = cls_fp;
            wb_wdata    = pipe_data;
        end else if (fpq_head_vld) begin
            fpq_pop     = 1'b1;
            wb_inst     = {20'b0, fpq_head.rd, 7'b0010011};
            wb_wdata    = fpq_head.result;
            wb_regwen   = ~fpq_head.fp_dest & (fpq_head.rd != 5'd0);
            wb_fpregwen = fpq_head.fp_dest;
        end
    end

    // Count cycles a full queue goes undrained; any pop resets, the count saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fpq_pop) begin
            starve_cnt <= '0;
        end else if (fpq_full && (starve_cnt < SCW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

    assign wb_stall_req = (starve_cnt >= SCW'(STARVE_LIMIT));
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_stall;
    logic [31:0] mem_inst;
    logic [31:0] mem_pc;
    logic [31:0] mem_alu;
    logic [31:0] wb_dmem_rdata;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic        fpu_fp_dest;
    logic [31:0] fpu_result;
    logic        fpu_ready;
    logic        wb_regwen;
    logic        wb_fpregwen;
    logic [31:0] wb_wdata;
    logic [31:0] wb_inst;
    logic        wb_stall_req;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] SW_I   = 32'h00A1_2223;
    localparam logic [31:0] ADDI1  = 32'h0010_0093;
    localparam logic [31:0] ADD2   = 32'h0000_0133;

    wb_stage #(.FPQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_stall     (mem_stall),
        .mem_inst      (mem_inst),
        .mem_pc        (mem_pc),
        .mem_alu       (mem_alu),
        .wb_dmem_rdata (wb_dmem_rdata),
        .fpu_valid     (fpu_valid),
        .fpu_rd        (fpu_rd),
        .fpu_fp_dest   (fpu_fp_dest),
        .fpu_result    (fpu_result),
        .fpu_ready     (fpu_ready),
        .wb_regwen     (wb_regwen),
        .wb_fpregwen   (wb_fpregwen),
        .wb_wdata      (wb_wdata),
        .wb_inst       (wb_inst),
        .wb_stall_req  (wb_stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        e_regwen;
        logic        e_fpregwen;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           inst          pc            alu           rdata         rw    fw    wdata
        vecs[0]  = '{32'h00000283, 32'h00000100, 32'h00001003, 32'h80FF1122, 1'b1, 1'b0, 32'hFFFFFF80}; // LB x5
        vecs[1]  = '{32'h00005283, 32'h00000104, 32'h00001002, 32'h80FF1122, 1'b1, 1'b0, 32'h000080FF}; // LHU x5
        vecs[2]  = '{32'h00001303, 32'h00000108, 32'h00001000, 32'h80FF9122, 1'b1, 1'b0, 32'hFFFF9122}; // LH x6
        vecs[3]  = '{32'h00002383, 32'h0000010C, 32'h00001004, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF}; // LW x7
        vecs[4]  = '{32'h00004403, 32'h00000110, 32'h00001001, 32'h80FF1122, 1'b1, 1'b0, 32'h00000011}; // LBU x8
        vecs[5]  = '{32'h000000EF, 32'hFFFFFFFC, 32'h00000040, 32'h00000000, 1'b1, 1'b0, 32'h00000000}; // JAL x1 wrap
        vecs[6]  = '{32'h00000013, 32'h00000118, 32'h00000055, 32'h00000000, 1'b0, 1'b0, 32'h00000000}; // ADDI x0
        vecs[7]  = '{32'h00000193, 32'h0000011C, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345678}; // ADDI x3
        vecs[8]  = '{32'h00002107, 32'h00000120, 32'h00002000, 32'h40490FDB, 1'b0, 1'b1, 32'h40490FDB}; // FLW f2
        vecs[9]  = '{32'h000000D3, 32'h00000124, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 32'h3F000000}; // FADD.S f1
        vecs[10] = '{32'hE0000553, 32'h00000128, 32'h0000ABCD, 32'h00000000, 1'b1, 1'b0, 32'h0000ABCD}; // FMV.X.W x10
        vecs[11] = '{32'h18000253, 32'h0000012C, 32'h0000BEEF, 32'h00000000, 1'b0, 1'b0, 32'h00000000}; // FDIV f4
        vecs[12] = '{SW_I,         32'h00000130, 32'h00003000, 32'h00000000, 1'b0, 1'b0, 32'h00000000}; // SW
        vecs[13] = '{32'h000002C3, 32'h00000134, 32'h11111111, 32'h00000000, 1'b0, 1'b1, 32'h11111111}; // FMADD f5
        vecs[14] = '{32'hC0000053, 32'h00000138, 32'h00000009, 32'h00000000, 1'b0, 1'b0, 32'h00000000}; // FCVT.W.S x0
        vecs[15] = '{32'h00000497, 32'h0000013C, 32'h00001000, 32'h00000000, 1'b1, 1'b0, 32'h00001000}; // AUIPC x9

        rst = 1'b1; mem_stall = 1'b0; mem_inst = NOP; mem_pc = '0; mem_alu = '0;
        wb_dmem_rdata = '0; fpu_valid = 1'b0; fpu_rd = '0; fpu_fp_dest = 1'b0; fpu_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_regwen",   32'(wb_regwen),    32'd0);
        chk("rst_fpregwen", 32'(wb_fpregwen),  32'd0);
        chk("rst_wdata",    wb_wdata,          32'd0);
        chk("rst_inst",     wb_inst,           NOP);
        chk("rst_ready",    32'(fpu_ready),    32'd1);
        chk("rst_stall",    32'(wb_stall_req), 32'd0);

        // Table-driven single-instruction writeback vectors, queue empty.
        for (int i = 0; i < 16; i++) begin
            mem_inst = vecs[i].inst;
            mem_pc   = vecs[i].pc;
            mem_alu  = vecs[i].alu;
            @(posedge clk);
            #1 wb_dmem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_regwen", i),   32'(wb_regwen),   32'(vecs[i].e_regwen));
            chk($sformatf("v%0d_fpregwen", i), 32'(wb_fpregwen), 32'(vecs[i].e_fpregwen));
            chk($sformatf("v%0d_wdata", i),    wb_wdata,         vecs[i].e_wdata);
            chk($sformatf("v%0d_inst", i),     wb_inst,          vecs[i].inst);
        end

        // FPU result returned while a store occupies WB; no same-cycle bypass.
        mem_inst = SW_I; mem_alu = '0; wb_dmem_rdata = '0;
        cyc();
        fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_fp_dest = 1'b1; fpu_result = 32'h3F800000;
        #1;
        chk("fpq_nobypass_fpregwen", 32'(wb_fpregwen), 32'd0);
        chk("fpq_nobypass_wdata",    wb_wdata,         32'd0);
        cyc();
        fpu_valid = 1'b0;
        chk("fpq_fpregwen", 32'(wb_fpregwen), 32'd1);
        chk("fpq_regwen",   32'(wb_regwen),   32'd0);
        chk("fpq_inst",     wb_inst,          32'h00000393);
        chk("fpq_wdata",    wb_wdata,         32'h3F800000);
        cyc();
        chk("fpq_drained_fpregwen", 32'(wb_fpregwen), 32'd0);

        // Fill the queue under back-to-back ADDIs and watch starvation build.
        mem_inst = ADDI1; mem_alu = 32'h1;
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_fp_dest = 1'b0; fpu_result = 32'hAAAA0001;
        cyc();
        chk("fill1_ready", 32'(fpu_ready), 32'd1);
        fpu_rd = 5'd4; fpu_result = 32'hAAAA0002;
        cyc();
        fpu_valid = 1'b0;
        chk("full_ready",  32'(fpu_ready),    32'd0);
        chk("full_stall0", 32'(wb_stall_req), 32'd0);
        chk("full_inst",   wb_inst,           ADDI1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("starve%0d_stall", k), 32'(wb_stall_req), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d_inst", k),  wb_inst,           ADDI1);
        end
        // Bubble with an ADD in MEM: WB sees NOP and the head drains.
        mem_stall = 1'b1; mem_inst = ADD2; mem_alu = 32'h77;
        cyc();
        mem_stall = 1'b0;
        chk("bubble_inst",   wb_inst,           32'h00000193);
        chk("bubble_wdata",  wb_wdata,          32'hAAAA0001);
        chk("bubble_regwen", 32'(wb_regwen),    32'd1);
        chk("bubble_fpwen",  32'(wb_fpregwen),  32'd0);
        chk("bubble_stall",  32'(wb_stall_req), 32'd1);
        cyc();
        chk("after_stall", 32'(wb_stall_req), 32'd0);
        chk("after_ready", 32'(fpu_ready),    32'd1);
        chk("after_inst",  wb_inst,           ADD2);
        chk("after_wdata", wb_wdata,          32'h77);
        mem_inst = SW_I;
        cyc();
        chk("drain2_inst",   wb_inst,        32'h00000213);
        chk("drain2_wdata",  wb_wdata,       32'hAAAA0002);
        chk("drain2_regwen", 32'(wb_regwen), 32'd1);
        cyc();
        chk("empty_regwen", 32'(wb_regwen), 32'd0);
        chk("empty_wdata",  wb_wdata,       32'd0);

        // Reset mid-operation with two entries queued.
        mem_inst = ADDI1;
        fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_fp_dest = 1'b1; fpu_result = 32'h12121212;
        cyc();
        cyc();
        fpu_valid = 1'b0;
        chk("prerst_ready", 32'(fpu_ready), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_ready",    32'(fpu_ready),    32'd1);
        chk("midrst_inst",     wb_inst,           NOP);
        chk("midrst_regwen",   32'(wb_regwen),    32'd0);
        chk("midrst_fpregwen", 32'(wb_fpregwen),  32'd0);
        chk("midrst_stall",    32'(wb_stall_req), 32'd0);
        mem_inst = SW_I;
        cyc();
        chk("postrst_fpregwen", 32'(wb_fpregwen), 32'd0);
        chk("postrst_wdata",    wb_wdata,         32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
